// File: rtl/ipv4_hdr_gen.sv
// IPv4 header generator: captures header fields, computes the ones-complement
// checksum and streams the 20-byte header behind an L2 tail on a 64-bit bus.
module ipv4_hdr_gen (
  input  logic        clk_i,
  input  logic        srst_i,
  input  logic        en_i,
  input  logic        start_i,
  input  logic        ip_6b_n2b_start_i,
  input  logic [47:0] l2_tail_i,
  input  logic [7:0]  ip_tos_i,
  input  logic [15:0] ip_total_len_i,
  input  logic [15:0] ip_ident_i,
  input  logic [15:0] ip_flags_offset_i,
  input  logic [7:0]  ip_ttl_i,
  input  logic [7:0]  ip_prot_i,
  input  logic [31:0] ip_src_i,
  input  logic [31:0] ip_dst_i,
  input  logic        pkt_ready_i,
  output logic [63:0] pkt_data_o,
  output logic [2:0]  pkt_mod_o,
  output logic        pkt_sop_o,
  output logic        pkt_eop_o,
  output logic        pkt_en_o,
  output logic [15:0] ip_csum_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, SUM, FOLD, EMIT} state_t;

  state_t      state;
  logic        off6;
  logic [47:0] l2_tail;
  logic [7:0]  tos, ttl, prot;
  logic [15:0] total_len, ident, flags_offset;
  logic [31:0] src, dst;
  logic [19:0] sum;
  logic [1:0]  idx;

  logic [19:0]  sum_next, fold1, fold2;
  logic [15:0]  csum_val;
  logic [159:0] ip_hdr;
  logic [255:0] frame;
  logic [1:0]   next_idx, last_idx;
  logic [2:0]   last_mod;
  logic [63:0]  next_word;

  // The checksum is folded combinationally during FOLD so the frame image can
  // already carry it when word 0 is loaded; afterwards the held register is used.
  always_comb begin
    sum_next = {4'h0, 8'h45, tos} + {4'h0, total_len} + {4'h0, ident}
             + {4'h0, flags_offset} + {4'h0, ttl, prot}
             + {4'h0, src[31:16]} + {4'h0, src[15:0]}
             + {4'h0, dst[31:16]} + {4'h0, dst[15:0]};
    fold1    = {4'h0, sum[15:0]} + {16'h0, sum[19:16]};
    fold2    = {4'h0, fold1[15:0]} + {16'h0, fold1[19:16]};
    csum_val = (state == FOLD) ? ~fold2[15:0] : ip_csum_o;
    ip_hdr   = {8'h45, tos, total_len, ident, flags_offset, ttl, prot,
                csum_val, src, dst};
    frame    = off6 ? {l2_tail, ip_hdr, 48'h0}
                    : {l2_tail[15:0], ip_hdr, 16'h0, 64'h0};
    last_idx = off6 ? 2'd3 : 2'd2;
    last_mod = off6 ? 3'd2 : 3'd6;
    next_idx = idx + 2'd1;
    case (next_idx)
      2'd0:    next_word = frame[255:192];
      2'd1:    next_word = frame[191:128];
      2'd2:    next_word = frame[127:64];
      default: next_word = frame[63:0];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state      <= IDLE;
      pkt_data_o <= '0;
      pkt_mod_o  <= '0;
      pkt_sop_o  <= 1'b0;
      pkt_eop_o  <= 1'b0;
      pkt_en_o   <= 1'b0;
      busy_o     <= 1'b0;
      ip_csum_o  <= '0;
      idx        <= '0;
      sum        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en_i && start_i) begin
            off6         <= ip_6b_n2b_start_i;
            l2_tail      <= l2_tail_i;
            tos          <= ip_tos_i;
            total_len    <= ip_total_len_i;
            ident        <= ip_ident_i;
            flags_offset <= ip_flags_offset_i;
            ttl          <= ip_ttl_i;
            prot         <= ip_prot_i;
            src          <= ip_src_i;
            dst          <= ip_dst_i;
            busy_o       <= 1'b1;
            state        <= SUM;
          end
        end
        SUM: begin
          sum   <= sum_next;
          state <= FOLD;
        end
        FOLD: begin
          ip_csum_o  <= csum_val;
          pkt_data_o <= frame[255:192];
          pkt_sop_o  <= 1'b1;
          pkt_eop_o  <= 1'b0;
          pkt_mod_o  <= '0;
          pkt_en_o   <= 1'b1;
          idx        <= '0;
          state      <= EMIT;
        end
        EMIT: begin
          if (pkt_ready_i) begin
            if (pkt_eop_o) begin
              pkt_data_o <= '0;
              pkt_mod_o  <= '0;
              pkt_sop_o  <= 1'b0;
              pkt_eop_o  <= 1'b0;
              pkt_en_o   <= 1'b0;
              busy_o     <= 1'b0;
              state      <= IDLE;
            end else begin
              idx        <= next_idx;
              pkt_data_o <= next_word;
              pkt_sop_o  <= 1'b0;
              pkt_eop_o  <= (next_idx == last_idx);
              pkt_mod_o  <= (next_idx == last_idx) ? last_mod : 3'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_hdr_gen.sv
// Randomized self-checking bench for ipv4_hdr_gen against a byte-level
// reference model of the header image and an arithmetic checksum.
module tb_ipv4_hdr_gen;

  typedef struct {
    logic        off6;
    logic [47:0] l2;
    logic [7:0]  tos, ttl, prot;
    logic [15:0] len, ident, floff;
    logic [31:0] src, dst;
  } hdr_t;

  logic        clk = 1'b0;
  logic        srst, en, start, off6, ready;
  logic [47:0] l2;
  logic [7:0]  tos, ttl, prot;
  logic [15:0] len, ident, floff;
  logic [31:0] src, dst;
  logic [63:0] pkt_data;
  logic [2:0]  pkt_mod;
  logic        pkt_sop, pkt_eop, pkt_en, busy;
  logic [15:0] ip_csum;

  int n_checks = 0;
  int n_fail = 0;

  logic [63:0] exp_words [8];
  int          exp_n;
  logic [2:0]  exp_mod;
  logic [15:0] exp_csum;

  always #5 clk = ~clk;

  ipv4_hdr_gen dut (
    .clk_i(clk), .srst_i(srst), .en_i(en), .start_i(start),
    .ip_6b_n2b_start_i(off6), .l2_tail_i(l2), .ip_tos_i(tos),
    .ip_total_len_i(len), .ip_ident_i(ident), .ip_flags_offset_i(floff),
    .ip_ttl_i(ttl), .ip_prot_i(prot), .ip_src_i(src), .ip_dst_i(dst),
    .pkt_ready_i(ready), .pkt_data_o(pkt_data), .pkt_mod_o(pkt_mod),
    .pkt_sop_o(pkt_sop), .pkt_eop_o(pkt_eop), .pkt_en_o(pkt_en),
    .ip_csum_o(ip_csum), .busy_o(busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, expv);
    end
  endtask

  function automatic hdr_t randomHdr();
    hdr_t h;
    h.off6  = 1'($urandom_range(0, 1));
    h.l2    = {16'($urandom), 32'($urandom)};
    h.tos   = 8'($urandom);
    h.len   = 16'($urandom);
    h.ident = 16'($urandom);
    h.floff = 16'($urandom);
    h.ttl   = 8'($urandom);
    h.prot  = 8'($urandom);
    h.src   = $urandom;
    h.dst   = $urandom;
    return h;
  endfunction

  task automatic setFields(input hdr_t h);
    off6 = h.off6; l2 = h.l2; tos = h.tos; len = h.len; ident = h.ident;
    floff = h.floff; ttl = h.ttl; prot = h.prot; src = h.src; dst = h.dst;
  endtask

  // Reference: ones-complement sum folded until no carry remains, then the
  // wire byte sequence (L2 tail, 20 IP bytes, zero pad) chopped into words.
  task automatic buildModel(input hdr_t h);
    int unsigned s;
    logic [7:0]  q[$];
    int          pre;
    s = 32'h4500 + h.tos + h.len + h.ident + h.floff + {h.ttl, h.prot}
      + h.src[31:16] + h.src[15:0] + h.dst[31:16] + h.dst[15:0];
    while ((s >> 16) != 0) s = (s & 32'hffff) + (s >> 16);
    exp_csum = ~s[15:0];
    pre = h.off6 ? 6 : 2;
    for (int i = pre - 1; i >= 0; i--) q.push_back(h.l2[i*8 +: 8]);
    q.push_back(8'h45); q.push_back(h.tos);
    q.push_back(h.len[15:8]); q.push_back(h.len[7:0]);
    q.push_back(h.ident[15:8]); q.push_back(h.ident[7:0]);
    q.push_back(h.floff[15:8]); q.push_back(h.floff[7:0]);
    q.push_back(h.ttl); q.push_back(h.prot);
    q.push_back(exp_csum[15:8]); q.push_back(exp_csum[7:0]);
    for (int i = 3; i >= 0; i--) q.push_back(h.src[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(h.dst[i*8 +: 8]);
    exp_mod = 3'((pre + 20) % 8);
    while (q.size() % 8 != 0) q.push_back(8'h00);
    exp_n = q.size() / 8;
    for (int w = 0; w < 8; w++) exp_words[w] = '0;
    for (int w = 0; w < exp_n; w++)
      for (int b = 0; b < 8; b++) exp_words[w][63 - 8*b -: 8] = q[w*8 + b];
  endtask

  // Issues one request and follows it to the end. stall_word/stall_n hold
  // ready low on one word; noise scrambles fields/en and pulses start while
  // busy; rst_word >= 0 fires srst when that word is presented.
  task automatic applyStimulus(input hdr_t h, input int stall_word, input int stall_n,
                               input bit noise, input int rst_word);
    int cyc, got, stalls;
    bit done, seen;
    buildModel(h);
    setFields(h);
    en = 1'b1; start = 1'b1; ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; got = 0; stalls = 0; done = 1'b0; seen = 1'b0;
    if (noise) setFields(randomHdr());
    checkOutput("busy_after_start", busy, 1);
    while (!done && cyc < 60) begin
      start = 1'b0;
      if (noise) begin
        en = 1'($urandom_range(0, 1));
        if (pkt_en && !pkt_eop) start = 1'($urandom_range(0, 1));
      end
      if (rst_word >= 0 && pkt_en && got == rst_word) begin
        srst = 1'b1;
        @(posedge clk); #1;
        srst = 1'b0; start = 1'b0; en = 1'b1;
        checkOutput("rst_mid_en", pkt_en, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_csum", ip_csum, 0);
        return;
      end
      ready = !(pkt_en && got == stall_word && stalls < stall_n);
      if (!ready) stalls++;
      @(negedge clk);
      if (pkt_en) begin
        if (!seen) begin
          checkOutput("first_word_latency", cyc, 3);
          seen = 1'b1;
        end
        checkOutput($sformatf("word%0d_data", got), pkt_data, exp_words[got]);
        checkOutput($sformatf("word%0d_sop", got), pkt_sop, got == 0);
        checkOutput($sformatf("word%0d_eop", got), pkt_eop, got == exp_n - 1);
        checkOutput($sformatf("word%0d_mod", got), pkt_mod,
                    (got == exp_n - 1) ? exp_mod : 3'd0);
        checkOutput("csum_during_emit", ip_csum, exp_csum);
        if (ready) begin
          got++;
          if (pkt_eop) done = 1'b1;
        end
      end else if (seen) begin
        checkOutput("en_held_until_eop", pkt_en, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; en = 1'b1; ready = 1'b1;
    checkOutput("eop_seen", done, 1);
    checkOutput("word_count", got, exp_n);
    checkOutput("csum_held", ip_csum, exp_csum);
    checkOutput("en_after_eop", pkt_en, 0);
    checkOutput("busy_after_eop", busy, 0);
  endtask

  initial begin
    hdr_t h;
    srst = 1'b1; en = 1'b0; start = 1'b0; ready = 1'b1;
    setFields(randomHdr());
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_data", pkt_data, 0);
    checkOutput("rst_mod", pkt_mod, 0);
    checkOutput("rst_sop", pkt_sop, 0);
    checkOutput("rst_eop", pkt_eop, 0);
    checkOutput("rst_en", pkt_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_csum", ip_csum, 0);
    srst = 1'b0;
    @(posedge clk); #1;

    h.off6 = 1'b0; h.l2 = 48'h0000_0000_0800; h.tos = 8'h00; h.len = 16'h0073;
    h.ident = 16'h0000; h.floff = 16'h4000; h.ttl = 8'h40; h.prot = 8'h11;
    h.src = 32'hc0a8_0001; h.dst = 32'hc0a8_00c7;
    applyStimulus(h, -1, 0, 1'b0, -1);
    checkOutput("vec_off2_csum", ip_csum, 16'hb861);

    // Back-to-back: issued on the cycle busy falls.
    h.off6 = 1'b1; h.l2 = 48'h1122_3344_0800;
    applyStimulus(h, -1, 0, 1'b0, -1);
    checkOutput("vec_off6_csum", ip_csum, 16'hb861);

    h.off6 = 1'b0; h.l2 = '1; h.tos = '1; h.len = '1; h.ident = '1; h.floff = '1;
    h.ttl = '1; h.prot = '1; h.src = '1; h.dst = '1;
    applyStimulus(h, -1, 0, 1'b0, -1);
    checkOutput("all_ones_csum", ip_csum, 16'hba00);

    h = randomHdr(); h.off6 = 1'b0;
    applyStimulus(h, 1, 4, 1'b0, -1);

    en = 1'b0; start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("start_en_low_ignored", busy, 0);
    end
    start = 1'b0; en = 1'b1;

    applyStimulus(randomHdr(), -1, 0, 1'b1, -1);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("no_queued_start", busy, 0);
    end

    applyStimulus(randomHdr(), -1, 0, 1'b0, 1);
    applyStimulus(randomHdr(), -1, 0, 1'b0, -1);

    for (int i = 0; i < 20; i++)
      applyStimulus(randomHdr(), $urandom_range(0, 4), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
